spart_result_unloader: RTL and testbench
========================================

Name: spart_result_unloader

Overview:
Return-path companion to the SPART program/data loader. When the CPU halts, it reads result entries from the HASH, ENCRYPT and DECRYPT result BRAMs and serializes them into 16-bit words. Words go out through a write-address/valid/ready port toward the host-side SPART buffer. The stream uses the same opcode-tagged framing the loader consumes, so the host parses results with the loader's decode rules.

Parameters:
- BASE_ADDR, 16'h8000, host-side byte address of the first output word; advances by 2 per word.
- HASH_WORDS, 32, 16-bit words per 512-bit hash entry.
- BLK_WORDS, 8, 16-bit words per 128-bit encrypt/decrypt entry.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse from CPU halt; sampled only in IDLE
- hash_cnt  input  5  hash entries to unload (0..16; values above 16 saturate to 16)
- enc_cnt  input  6  encrypt entries (0..32; saturate)
- dec_cnt  input  6  decrypt entries (0..32; saturate)
- hash_rd_addr  output  4  hash BRAM read address
- hash_rd_data  input  512  hash BRAM data, 1-cycle read latency
- enc_rd_addr  output  5  encrypt BRAM read address
- enc_rd_data  input  128  encrypt BRAM data, 1-cycle latency
- dec_rd_addr  output  5  decrypt BRAM read address
- dec_rd_data  input  128  decrypt BRAM data, 1-cycle latency
- w_addr  output  16  host write address
- w_data  output  16  host write data
- w_en  output  1  word valid
- w_rdy  input  1  host accepts word
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse after the final word transfers

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs 0; w_addr=BASE_ADDR. Internal counters and the shift buffer clear. Reset asserted mid-operation aborts immediately; no further words are emitted.
- Counts latch on start. start while busy is ignored.
- Transfer rule: a word moves when w_en & w_rdy. While w_en & ~w_rdy, w_data and w_addr hold stable. w_en never drops without a transfer.
- Region order: HASH, ENCR, DECR. A region with count 0 is skipped entirely.
- Entry framing:
  - Header word {opcode[4:0], 6'b0, idx[4:0]}. Opcodes: HASH 5'b11100, ENCR 5'b11101, DECR 5'b11110, HALT 5'b11111. idx is the entry number within its region.
  - Payload follows, most-significant 16 bits first: hash [511:496] first, enc/dec [127:112] first.
- Stream end: trailer word 16'hF800 (HALT, idx 0).
- FSM states and transitions:
  - IDLE: on start, go to HDR; busy rises the next cycle.
  - HDR: w_en=1 with the header word; the BRAM read address for idx is driven. On transfer, go to LOAD.
  - LOAD: one cycle; the shift buffer captures rd_data; go to DATA.
  - DATA: words shift out MSW-first, counted to HASH_WORDS or BLK_WORDS. After the last payload transfer: next idx → HDR; region exhausted → next non-empty region HDR; otherwise → TRAIL.
  - TRAIL: emit trailer; on transfer, go to IDLE with done=1 for one cycle and busy=0.
- Latency with w_rdy held high:
  - First header is valid 1 cycle after start.
  - Each entry costs 1 + 1 + N cycles (header, LOAD, N payload words).
  - done asserts the cycle after the trailer transfer.
- w_addr increments by 2 per transfer and wraps at 16'hFFFE → 16'h0000.
- Read addresses change only in HDR. This meets the BRAM 1-cycle latency before LOAD.

Optional Feature:
SPART_UNLOAD_CKSUM_EN:
- Defined: a checksum word is inserted immediately before the trailer. Its value is the XOR of every previously emitted header and payload word, with an extra CKSUM state.
- Undefined: the trailer follows the last payload directly, and no checksum logic exists.

Decomposition:
- Shared package spart_pkg holds:
  - opcode localparams HASH/ENCR/DECR/HALT (also used by the loader);
  - unloader state enum;
  - region enum {REG_HASH, REG_ENC, REG_DEC};
  - HALT_WORD = 16'hF800.
- One natural sub-module: spart_word_serializer, a 512-bit shift buffer with word counter and valid/ready output stage. It is parameterized by word count and reused for 128-bit entries by loading into the top bits.

Test Plan:
- Single hash: hash_cnt=1, others 0, hash_rd_data[511:496]=16'hA5A5, w_rdy=1.
  → E000 at 8000, then 32 payload words (first A5A5 at 8002), then F800 at 8042; done asserts the cycle after.
- Mixed: hash_cnt=0, enc_cnt=2, dec_cnt=1.
  → Headers E800, E801, F000, each followed by 8 words; 28 words total including the trailer; last w_addr 8036.
- Empty: all counts 0.
  → Only F800 at 8000, then done.
- Backpressure: w_rdy toggles 1/0 every cycle during an enc entry.
  → No word dropped or duplicated; data and address stable during stalls; payload order matches MSW-first.
- Control: start while busy is ignored; rst_n low mid-DATA → w_en=0 immediately and w_addr=8000; a new start after reset replays from E000.
- With SPART_UNLOAD_CKSUM_EN: enc_cnt=1, data 128'h0001_0002_…_0008.
  → Checksum word = E800^0001^…^0008 = 16'hE808 before F800.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: opcodes, unloader FSM states, region ids and helpers.
// The SPART_UNLOAD_CKSUM_EN macro adds the checksum state to the unloader FSM.
package spart_pkg;

  localparam logic [4:0]  OP_HASH   = 5'b11100;
  localparam logic [4:0]  OP_ENCR   = 5'b11101;
  localparam logic [4:0]  OP_DECR   = 5'b11110;
  localparam logic [4:0]  OP_HALT   = 5'b11111;
  localparam logic [15:0] HALT_WORD = {OP_HALT, 11'b0};

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
    StData,
`ifdef SPART_UNLOAD_CKSUM_EN
    StCksum,
`endif
    StTrail
  } unload_state_e;

  typedef enum logic [1:0] {REG_HASH, REG_ENC, REG_DEC} region_e;

  typedef struct packed {
    logic    found;
    region_e region;
  } region_pick_t;

  // avail bit 0 = hash, 1 = encrypt, 2 = decrypt; lowest set bit wins.
  function automatic region_pick_t pick_region(input logic [2:0] avail);
    region_pick_t p;
    p.found  = 1'b1;
    p.region = REG_HASH;
    if (avail[0])      p.region = REG_HASH;
    else if (avail[1]) p.region = REG_ENC;
    else if (avail[2]) p.region = REG_DEC;
    else               p.found  = 1'b0;
    return p;
  endfunction

  function automatic logic [2:0] regions_after(input region_e r);
    logic [2:0] m;
    case (r)
      REG_HASH: m = 3'b110;
      REG_ENC:  m = 3'b100;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] hdr_word(input region_e r, input logic [4:0] idx);
    logic [4:0] op;
    case (r)
      REG_HASH: op = OP_HASH;
      REG_ENC:  op = OP_ENCR;
      default:  op = OP_DECR;
    endcase
    return {op, 6'b0, idx};
  endfunction

endpackage

// File: rtl/spart_word_serializer.sv
// Left-justified shift buffer emitting 16-bit words MSW-first through a valid/ready stage.
// Narrow entries are loaded into the top bits with a smaller word count.
module spart_word_serializer #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_nwords,
  input  logic             i_rdy,
  output logic             o_valid,
  output logic [15:0]      o_data,
  output logic             o_last
);

  logic [WIDTH-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_xfer;

  assign w_xfer = r_valid & i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_cnt   <= i_nwords;
      r_valid <= (i_nwords != '0);
    end else if (w_xfer) begin
      r_buf <= {r_buf[WIDTH-17:0], 16'h0000};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_buf[WIDTH-1 -: 16];
  assign o_last  = w_xfer && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/spart_result_unloader.sv
// Streams HASH/ENCR/DECR result entries as opcode-framed 16-bit words, then a HALT trailer.
// Define SPART_UNLOAD_CKSUM_EN to insert an XOR checksum word before the trailer.
module spart_result_unloader
  import spart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h8000,
  parameter int unsigned HASH_WORDS = 32,
  parameter int unsigned BLK_WORDS  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   hash_cnt,
  input  logic [5:0]   enc_cnt,
  input  logic [5:0]   dec_cnt,
  output logic [3:0]   hash_rd_addr,
  input  logic [511:0] hash_rd_data,
  output logic [4:0]   enc_rd_addr,
  input  logic [127:0] enc_rd_data,
  output logic [4:0]   dec_rd_addr,
  input  logic [127:0] dec_rd_data,
  output logic [15:0]  w_addr,
  output logic [15:0]  w_data,
  output logic         w_en,
  input  logic         w_rdy,
  output logic         busy,
  output logic         done
);

  unload_state_e r_state;
  region_e       r_region;
  logic [4:0]    r_idx, r_hash_cnt;
  logic [5:0]    r_enc_cnt, r_dec_cnt;
  logic          r_hdr_valid, r_busy, r_done;
  logic [15:0]   r_hdr_data, r_addr;
  logic [3:0]    r_hash_addr;
  logic [4:0]    r_enc_addr, r_dec_addr;

  logic          w_ser_valid, w_ser_last, w_xfer, w_more, w_advance;
  logic [15:0]   w_ser_data;
  logic [511:0]  w_ser_in;
  logic [5:0]    w_ser_nwords, w_cur_cnt, w_enc_sat, w_dec_sat;
  logic [4:0]    w_hash_sat, w_nxt_idx;
  logic          w_nxt_found;
  region_e       w_nxt_region;
  region_pick_t  w_pick_start, w_pick_next;

  assign w_hash_sat = (hash_cnt > 5'd16) ? 5'd16 : hash_cnt;
  assign w_enc_sat  = (enc_cnt > 6'd32) ? 6'd32 : enc_cnt;
  assign w_dec_sat  = (dec_cnt > 6'd32) ? 6'd32 : dec_cnt;

  // Header/trailer and payload never overlap, so a simple OR/mux forms the output stage.
  assign w_en   = r_hdr_valid | w_ser_valid;
  assign w_data = w_ser_valid ? w_ser_data : r_hdr_data;
  assign w_xfer = w_en & w_rdy;

  always_comb begin
    w_ser_in     = hash_rd_data;
    w_ser_nwords = 6'(HASH_WORDS);
    w_cur_cnt    = {1'b0, r_hash_cnt};
    case (r_region)
      REG_ENC: begin
        w_ser_in     = {enc_rd_data, 384'b0};
        w_ser_nwords = 6'(BLK_WORDS);
        w_cur_cnt    = r_enc_cnt;
      end
      REG_DEC: begin
        w_ser_in     = {dec_rd_data, 384'b0};
        w_ser_nwords = 6'(BLK_WORDS);
        w_cur_cnt    = r_dec_cnt;
      end
      default: ;
    endcase
  end

  assign w_more       = ({1'b0, r_idx} + 6'd1) < w_cur_cnt;
  assign w_pick_start = pick_region({w_dec_sat != 6'd0, w_enc_sat != 6'd0, w_hash_sat != 5'd0});
  assign w_pick_next  = pick_region({r_dec_cnt != 6'd0, r_enc_cnt != 6'd0, r_hash_cnt != 5'd0}
                                    & regions_after(r_region));
  assign w_advance    = ((r_state == StIdle) && start) || ((r_state == StData) && w_ser_last);

  always_comb begin
    w_nxt_found  = w_pick_next.found;
    w_nxt_region = w_pick_next.region;
    w_nxt_idx    = 5'd0;
    if (r_state == StIdle) begin
      w_nxt_found  = w_pick_start.found;
      w_nxt_region = w_pick_start.region;
    end else if (w_more) begin
      w_nxt_found  = 1'b1;
      w_nxt_region = r_region;
      w_nxt_idx    = r_idx + 5'd1;
    end
  end

`ifdef SPART_UNLOAD_CKSUM_EN
  logic [15:0] r_cksum, w_cksum_fin;
  // Fold in the last payload word, which transfers on the same edge we leave DATA.
  assign w_cksum_fin = (r_state == StIdle) ? 16'h0000 : (r_cksum ^ w_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_region    <= REG_HASH;
      r_idx       <= '0;
      r_hash_cnt  <= '0;
      r_enc_cnt   <= '0;
      r_dec_cnt   <= '0;
      r_hdr_valid <= 1'b0;
      r_hdr_data  <= '0;
      r_addr      <= BASE_ADDR;
      r_hash_addr <= '0;
      r_enc_addr  <= '0;
      r_dec_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SPART_UNLOAD_CKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_xfer) r_addr <= r_addr + 16'd2;
`ifdef SPART_UNLOAD_CKSUM_EN
      if (w_xfer && (r_state == StHdr || r_state == StData)) r_cksum <= r_cksum ^ w_data;
`endif
      unique case (r_state)
        StIdle: if (start) begin
          r_busy     <= 1'b1;
          r_hash_cnt <= w_hash_sat;
          r_enc_cnt  <= w_enc_sat;
          r_dec_cnt  <= w_dec_sat;
          r_addr     <= BASE_ADDR;
`ifdef SPART_UNLOAD_CKSUM_EN
          r_cksum    <= '0;
`endif
        end
        StHdr: if (w_xfer) begin
          r_hdr_valid <= 1'b0;
          r_state     <= StLoad;
        end
        StLoad: r_state <= StData;
        StData: ;
`ifdef SPART_UNLOAD_CKSUM_EN
        StCksum: if (w_xfer) begin
          r_hdr_data <= HALT_WORD;
          r_state    <= StTrail;
        end
`endif
        StTrail: if (w_xfer) begin
          r_hdr_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (w_advance) begin
        r_hdr_valid <= 1'b1;
        if (w_nxt_found) begin
          r_state    <= StHdr;
          r_region   <= w_nxt_region;
          r_idx      <= w_nxt_idx;
          r_hdr_data <= hdr_word(w_nxt_region, w_nxt_idx);
          case (w_nxt_region)
            REG_HASH: r_hash_addr <= w_nxt_idx[3:0];
            REG_ENC:  r_enc_addr  <= w_nxt_idx;
            default:  r_dec_addr  <= w_nxt_idx;
          endcase
        end else begin
`ifdef SPART_UNLOAD_CKSUM_EN
          r_state    <= StCksum;
          r_hdr_data <= w_cksum_fin;
`else
          r_state    <= StTrail;
          r_hdr_data <= HALT_WORD;
`endif
        end
      end
    end
  end

  spart_word_serializer #(
    .WIDTH (512),
    .CNT_W (6)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (r_state == StLoad),
    .i_data   (w_ser_in),
    .i_nwords (w_ser_nwords),
    .i_rdy    (w_rdy),
    .o_valid  (w_ser_valid),
    .o_data   (w_ser_data),
    .o_last   (w_ser_last)
  );

  assign hash_rd_addr = r_hash_addr;
  assign enc_rd_addr  = r_enc_addr;
  assign dec_rd_addr  = r_dec_addr;
  assign w_addr       = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_spart_result_unloader.sv
// Bench for spart_result_unloader: directed framing cases plus randomized counts/backpressure
// against a word-list model. Honours SPART_UNLOAD_CKSUM_EN like the design.
`timescale 1ns/1ps
module tb_spart_result_unloader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   hash_cnt = '0;
  logic [5:0]   enc_cnt = '0;
  logic [5:0]   dec_cnt = '0;
  logic [3:0]   hash_rd_addr;
  logic [511:0] hash_rd_data;
  logic [4:0]   enc_rd_addr, dec_rd_addr;
  logic [127:0] enc_rd_data, dec_rd_data;
  logic [15:0]  w_addr, w_data;
  logic         w_en, busy, done;
  logic         w_rdy = 1'b1;

  logic [511:0] hash_mem [16];
  logic [127:0] enc_mem  [32];
  logic [127:0] dec_mem  [32];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          exp_cycles;
  logic [15:0] last_addr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hash_rd_data <= hash_mem[hash_rd_addr];
    enc_rd_data  <= enc_mem[enc_rd_addr];
    dec_rd_data  <= dec_mem[dec_rd_addr];
  end

  spart_result_unloader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hash_cnt     (hash_cnt),
    .enc_cnt      (enc_cnt),
    .dec_cnt      (dec_cnt),
    .hash_rd_addr (hash_rd_addr),
    .hash_rd_data (hash_rd_data),
    .enc_rd_addr  (enc_rd_addr),
    .enc_rd_data  (enc_rd_data),
    .dec_rd_addr  (dec_rd_addr),
    .dec_rd_data  (dec_rd_data),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .w_en         (w_en),
    .w_rdy        (w_rdy),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected word list and rdy-high cycle count (first header at cycle 0, done at exp_cycles).
  task automatic build_expected(input int h, input int e, input int d);
    int hs, es, ds;
    logic [15:0] x;
    hs = (h > 16) ? 16 : h;
    es = (e > 32) ? 32 : e;
    ds = (d > 32) ? 32 : d;
    exp_q.delete();
    exp_cycles = 0;
    for (int i = 0; i < hs; i++) begin
      exp_q.push_back({5'b11100, 6'b0, 5'(i)});
      for (int j = 0; j < 32; j++) exp_q.push_back(hash_mem[i][511-16*j -: 16]);
      exp_cycles += 34;
    end
    for (int i = 0; i < es; i++) begin
      exp_q.push_back({5'b11101, 6'b0, 5'(i)});
      for (int j = 0; j < 8; j++) exp_q.push_back(enc_mem[i][127-16*j -: 16]);
      exp_cycles += 10;
    end
    for (int i = 0; i < ds; i++) begin
      exp_q.push_back({5'b11110, 6'b0, 5'(i)});
      for (int j = 0; j < 8; j++) exp_q.push_back(dec_mem[i][127-16*j -: 16]);
      exp_cycles += 10;
    end
`ifdef SPART_UNLOAD_CKSUM_EN
    x = 16'h0000;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
    exp_cycles += 1;
`endif
    exp_q.push_back(16'hF800);
    exp_cycles += 1;
  endtask

  // mode 0: rdy high, 1: toggle, 2: random. poke: pulse start mid-stream.
  task automatic run_stream(input int h, input int e, input int d, input int mode, input bit poke);
    int k;
    bit got_done, prev_stall, last_xfer;
    logic [15:0] prev_data, prev_addr;
    build_expected(h, e, d);
    obs_q.delete();
    @(negedge clk);
    hash_cnt = 5'(h);
    enc_cnt  = 6'(e);
    dec_cnt  = 6'(d);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    hash_cnt = 5'($urandom);
    enc_cnt  = 6'($urandom);
    dec_cnt  = 6'($urandom);
    check("busy_rise", busy, 1);
    check("first_valid", w_en, 1);
    k = 0; got_done = 0; prev_stall = 0; last_xfer = 0;
    prev_data = '0; prev_addr = '0;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      start = poke && (cyc == 4);
      case (mode)
        0:       w_rdy = 1'b1;
        1:       w_rdy = (cyc % 2 == 0);
        default: w_rdy = 1'($urandom_range(0, 1));
      endcase
      if (last_xfer) begin
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        check("idle_en", w_en, 0);
        if (mode == 0) check("latency", cyc, exp_cycles);
        got_done = 1;
      end else begin
        check("busy_hold", busy, 1);
        if (done) check("done_early", done, 0);
        if (prev_stall) begin
          check("stall_en", w_en, 1);
          check("stall_data", w_data, prev_data);
          check("stall_addr", w_addr, prev_addr);
        end
        if (w_en && w_rdy) begin
          if (k < exp_q.size()) begin
            check("data", w_data, exp_q[k]);
            check("addr", w_addr, 16'(32'h8000 + 2 * k));
          end else begin
            check("extra_word", k, exp_q.size());
          end
          obs_q.push_back(w_data);
          last_addr = w_addr;
          k++;
          if (k == exp_q.size()) last_xfer = 1;
        end
        prev_stall = w_en && !w_rdy;
        prev_data  = w_data;
        prev_addr  = w_addr;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got_done) check("timeout", got_done, 1);
  endtask

  initial begin
    logic [127:0] seq_blk;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) hash_mem[i][32*j +: 32] = $urandom();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 4; j++) begin
        enc_mem[i][32*j +: 32] = $urandom();
        dec_mem[i][32*j +: 32] = $urandom();
      end

    #12;
    check("rst_en", w_en, 0);
    check("rst_addr", w_addr, 16'h8000);
    check("rst_data", w_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdaddr", {hash_rd_addr, enc_rd_addr, dec_rd_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single hash entry
    hash_mem[0][511:496] = 16'hA5A5;
    run_stream(1, 0, 0, 0, 0);
    check("sh_hdr", obs_q[0], 16'hE000);
    check("sh_word1", obs_q[1], 16'hA5A5);
`ifdef SPART_UNLOAD_CKSUM_EN
    check("sh_count", obs_q.size(), 35);
    check("sh_last_addr", last_addr, 16'h8044);
`else
    check("sh_count", obs_q.size(), 34);
    check("sh_last_addr", last_addr, 16'h8042);
`endif

    // Mixed regions, hash skipped
    run_stream(0, 2, 1, 0, 0);
    check("mx_hdr0", obs_q[0], 16'hE800);
    check("mx_hdr1", obs_q[9], 16'hE801);
    check("mx_hdr2", obs_q[18], 16'hF000);
`ifdef SPART_UNLOAD_CKSUM_EN
    check("mx_count", obs_q.size(), 29);
    check("mx_last_addr", last_addr, 16'h8038);
`else
    check("mx_count", obs_q.size(), 28);
    check("mx_last_addr", last_addr, 16'h8036);
`endif

    // Empty stream
    run_stream(0, 0, 0, 0, 0);
`ifdef SPART_UNLOAD_CKSUM_EN
    check("em_count", obs_q.size(), 2);
    check("em_cksum", obs_q[0], 16'h0000);
`else
    check("em_count", obs_q.size(), 1);
    check("em_trail", obs_q[0], 16'hF800);
`endif

    // Toggling backpressure over an encrypt entry, with a start pulse while busy
    run_stream(0, 1, 0, 1, 1);

`ifdef SPART_UNLOAD_CKSUM_EN
    seq_blk = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    enc_mem[0] = seq_blk;
    run_stream(0, 1, 0, 0, 0);
    check("ck_word", obs_q[9], 16'hE808);
    check("ck_trail", obs_q[10], 16'hF800);
`endif

    // Reset in the middle of DATA aborts the stream
    @(negedge clk);
    enc_cnt = 6'd1;
    start   = 1'b1;
    w_rdy   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_data_en", w_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_en", w_en, 0);
    check("abort_addr", w_addr, 16'h8000);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("abort_hold_en", w_en, 0);
    rst_n = 1'b1;
    run_stream(1, 0, 0, 0, 0);
    check("replay_hdr", obs_q[0], 16'hE000);

    // Randomized counts (including saturating values) and random backpressure
    for (int it = 0; it < 4; it++) begin
      int h, e, d;
      h = $urandom_range(0, 20);
      e = $urandom_range(0, 34);
      d = $urandom_range(0, 34);
      run_stream(h, e, d, $urandom_range(1, 2), (h + e + d) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
